// File: rtl/cordic_single_stage.sv
// -----------------------------------------------------------------------------
// cordic_single_stage
//
// One registered micro-rotation of a rotation-mode CORDIC in signed Qm.n fixed
// point. A parent pipeline chains these stages, feeding stage k the constants
// i = k and atan = atan(2^-k). Gain (K) compensation is the parent's job.
//
// Direction d = +1 when z_in >= 0, otherwise d = -1:
//   d=+1: x_out <= x_in - (y_in>>>i); y_out <= y_in + (x_in>>>i); z_out <= z_in - atan
//   d=-1: x_out <= x_in + (y_in>>>i); y_out <= y_in - (x_in>>>i); z_out <= z_in + atan
//
// Ports (W = m + n):
//   clk    in   1            rising-edge clock
//   rst    in   1            synchronous active-high reset, zeroes all outputs
//   x_in   in   W  signed    x coordinate
//   y_in   in   W  signed    y coordinate
//   z_in   in   W  signed    residual angle (radians)
//   i      in   iter_length  shift amount / iteration index
//   atan   in   W  signed    atan(2^-i)
//   x_out  out  W  signed    registered rotated x
//   y_out  out  W  signed    registered rotated y
//   z_out  out  W  signed    registered residual angle
//
// Latency is exactly one cycle; throughput one sample per cycle.
//
// Build option: define CORDIC_STAGE_SAT_EN to saturate each add/subtract
// result to the W-bit signed range instead of wrapping modulo 2^W.
// -----------------------------------------------------------------------------
module cordic_single_stage #(
  parameter int m           = 6,
  parameter int n           = 10,
  parameter int iter_length = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [m+n-1:0]   x_in,
  input  logic signed [m+n-1:0]   y_in,
  input  logic signed [m+n-1:0]   z_in,
  input  logic [iter_length-1:0]  i,
  input  logic signed [m+n-1:0]   atan,
  output logic signed [m+n-1:0]   x_out,
  output logic signed [m+n-1:0]   y_out,
  output logic signed [m+n-1:0]   z_out
);

  localparam int W = m + n;

  // Arithmetic right shift by a run-time amount. Any shift of W or more
  // collapses to pure sign bits (0 or -1).
  function automatic logic [W-1:0] ashr(input logic [W-1:0] v,
                                        input logic [iter_length-1:0] sh);
    logic [W-1:0] r;
    if (int'(sh) >= W) begin
      r = {W{v[W-1]}};
    end else begin
      r = $signed(v) >>> sh;
    end
    return r;
  endfunction

  // W-bit add (sub=0) or subtract (sub=1). Subtraction is a + ~b + 1, so the
  // overflow test looks at the sign of the inverted operand.
  function automatic logic [W-1:0] addsub(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic         sub);
    logic [W-1:0] bb;
    logic [W-1:0] r;
`ifdef CORDIC_STAGE_SAT_EN
    logic         ovf;
`endif
    bb = sub ? ~b : b;
    r  = a + bb + {{(W-1){1'b0}}, sub};
`ifdef CORDIC_STAGE_SAT_EN
    // Overflow only when both operands share a sign the result lacks.
    ovf = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    if (ovf) begin
      r = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      r = r;
    end
`endif
    return r;
  endfunction

  logic         d_neg;
  logic [W-1:0] xs;
  logic [W-1:0] ys;
  logic [W-1:0] x_d, y_d, z_d;
  logic [W-1:0] x_q, y_q, z_q;

  // Next-state datapath: direction, barrel shifts and the three add/subtracts.
  always_comb begin
    d_neg = z_in[W-1];
    xs    = ashr(x_in, i);
    ys    = ashr(y_in, i);
    x_d   = addsub(x_in, ys,   ~d_neg);
    y_d   = addsub(y_in, xs,    d_neg);
    z_d   = addsub(z_in, atan, ~d_neg);
  end

  // Output registers; reset wins over any sample presented on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= {W{1'b0}};
      y_q <= {W{1'b0}};
      z_q <= {W{1'b0}};
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
    end
  end

  assign x_out = x_q;
  assign y_out = y_q;
  assign z_out = z_q;

endmodule

// File: tb/tb_cordic_single_stage.sv
module tb_cordic_single_stage;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] x_in = 16'h0000;
  logic signed [15:0] y_in = 16'h0000;
  logic signed [15:0] z_in = 16'h0000;
  logic [3:0]         i = 4'd0;
  logic signed [15:0] atan = 16'h0000;
  logic signed [15:0] x_out, y_out, z_out;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] x, y, z, at;
    logic [3:0]  sh;
    logic [15:0] ex, ey, ez;
  } vec_t;

  vec_t        tbl[6];
  logic [47:0] exp_q[$];

  cordic_single_stage #(.m(6), .n(10), .iter_length(4)) dut (
    .clk(clk), .rst(rst), .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .i(i), .atan(atan), .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] fit(input int v);
`ifdef CORDIC_STAGE_SAT_EN
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  // Reference model with integer arithmetic.
  task automatic model(input logic [15:0] x, y, z, at, input logic [3:0] sh,
                       output logic [15:0] ex, ey, ez);
    logic signed [15:0] xs, ys;
    int xi, yi, zi, ai, xsi, ysi;
    xs = $signed(x) >>> sh;
    ys = $signed(y) >>> sh;
    xi = $signed(x); yi = $signed(y); zi = $signed(z); ai = $signed(at);
    xsi = xs; ysi = ys;
    if (zi >= 0) begin
      ex = fit(xi - ysi); ey = fit(yi + xsi); ez = fit(zi - ai);
    end else begin
      ex = fit(xi + ysi); ey = fit(yi - xsi); ez = fit(zi + ai);
    end
  endtask

  task automatic drive(input logic r, input logic [15:0] x, y, z, at,
                       input logic [3:0] sh, input logic [15:0] ex, ey, ez);
    @(negedge clk);
    rst = r; x_in = x; y_in = y; z_in = z; atan = at; i = sh;
    exp_q.push_back({ex, ey, ez});
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic collect(input string name);
    logic [47:0] e;
    @(posedge clk);
    #1;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got x=%h expected a queued result", name, x_out);
    end else begin
      n_tests--;
      e = exp_q.pop_front();
      chk({name, ".x"}, x_out, e[47:32]);
      chk({name, ".y"}, y_out, e[31:16]);
      chk({name, ".z"}, z_out, e[15:0]);
    end
  endtask

  task automatic run_vec(input logic r, input vec_t v, input string name);
    drive(r, v.x, v.y, v.z, v.at, v.sh,
          r ? 16'h0000 : v.ex, r ? 16'h0000 : v.ey, r ? 16'h0000 : v.ez);
    collect(name);
  endtask

  initial begin
    logic [15:0] rx, ry, rz, ra, ex, ey, ez;
    logic [3:0]  rs;

    tbl[0] = '{16'h0400, 16'h0000, 16'h0324, 16'h0324, 4'd0,  16'h0400, 16'h0400, 16'h0000};
    tbl[1] = '{16'h0400, 16'h0200, 16'hFF00, 16'h01DA, 4'd1,  16'h0500, 16'h0000, 16'h00DA};
    tbl[2] = '{16'hF800, 16'h0000, 16'h0000, 16'h00FA, 4'd2,  16'hF800, 16'hFE00, 16'hFF06};
`ifdef CORDIC_STAGE_SAT_EN
    tbl[3] = '{16'h7000, 16'h7000, 16'h0000, 16'h0000, 4'd0,  16'h0000, 16'h7FFF, 16'h0000};
`else
    tbl[3] = '{16'h7000, 16'h7000, 16'h0000, 16'h0000, 4'd0,  16'h0000, 16'hE000, 16'h0000};
`endif
    tbl[4] = '{16'h8000, 16'h0001, 16'h0000, 16'h0001, 4'd15, 16'h8000, 16'h0000, 16'hFFFF};
    tbl[5] = '{16'h8000, 16'h0001, 16'hFFFF, 16'h0001, 4'd15, 16'h8000, 16'h0002, 16'h0000};

    // Reset overrides a non-zero sample, held for two edges.
    drive(1'b1, 16'h1234, 16'h5678, 16'h1111, 16'h0222, 4'd3, 16'h0000, 16'h0000, 16'h0000);
    collect("reset0");
    drive(1'b1, 16'h7FFF, 16'h8000, 16'hF000, 16'h0100, 4'd1, 16'h0000, 16'h0000, 16'h0000);
    collect("reset1");

    // Directed table, one vector at a time.
    for (int k = 0; k < 6; k++) run_vec(1'b0, tbl[k], $sformatf("vec%0d", k));

    // Stream 1-3 back to back with reset during the second sample.
    run_vec(1'b0, tbl[0], "stream0");
    run_vec(1'b1, tbl[1], "stream1_rst");
    run_vec(1'b0, tbl[2], "stream2");
    run_vec(1'b0, tbl[1], "stream3");

    // Randomised vectors against the integer model.
    for (int k = 0; k < 40; k++) begin
      rx = 16'($urandom); ry = 16'($urandom); rz = 16'($urandom);
      ra = 16'($urandom_range(0, 1023)); rs = 4'($urandom_range(0, 15));
      model(rx, ry, rz, ra, rs, ex, ey, ez);
      drive(1'b0, rx, ry, rz, ra, rs, ex, ey, ez);
      collect($sformatf("rand%0d", k));
    end

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d leftover results, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
